// File: rtl/tmr_scrub_ctrl.sv
// rtl/tmr_scrub_ctrl.sv - periodic 2-of-3 majority scrubber for a triplicated register bank
// Define TMR_SCRUB_LOG_EN to add the last-error log outputs err_addr / err_syndrome.
module tmr_scrub_ctrl #(
  parameter int N_WORDS  = 8,
  parameter int W        = 8,
  parameter int INTERVAL = 16,
  parameter int CNT_W    = 8,
  localparam int AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scrub_en,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [W-1:0]     rd_copy0,
  input  logic [W-1:0]     rd_copy1,
  input  logic [W-1:0]     rd_copy2,
  output logic             wr_req,
  input  logic             wr_gnt,
  output logic [AW-1:0]    wr_addr,
  output logic [W-1:0]     wr_data,
  input  logic             func_wr,
  input  logic [AW-1:0]    func_addr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             multi_err,
  output logic             busy
`ifdef TMR_SCRUB_LOG_EN
  ,
  output logic [AW-1:0]    err_addr,
  output logic [2:0]       err_syndrome
`endif
);

  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [IW-1:0]    CNT_LOAD  = IW'(INTERVAL - 1);
  localparam logic [AW-1:0]    ADDR_LAST = AW'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_CHECK, S_WRITE, S_NEXT
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    addr;
  logic [IW-1:0]    ivl_cnt;
  logic [W-1:0]     wr_data_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             multi_q;
  logic [W-1:0]     voted;
  logic [2:0]       syn;
  logic             mismatch, multi, collide;

  assign voted    = (rd_copy0 & rd_copy1) | (rd_copy1 & rd_copy2) | (rd_copy0 & rd_copy2);
  assign syn      = {rd_copy2 != voted, rd_copy1 != voted, rd_copy0 != voted};
  assign mismatch = |syn;
  assign multi    = (syn[0] & syn[1]) | (syn[1] & syn[2]) | (syn[0] & syn[2]);
  // A functional write to the word under scrub makes the voted data stale.
  assign collide  = func_wr && (func_addr == addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (scrub_en) state_nxt = S_WAIT;
      S_WAIT:  if (ivl_cnt == '0) state_nxt = scrub_en ? S_READ : S_IDLE;
      S_READ:  state_nxt = S_CHECK;
      S_CHECK: state_nxt = (!collide && mismatch) ? S_WRITE : S_NEXT;
      S_WRITE: if (collide || wr_gnt) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      ivl_cnt   <= '0;
      wr_data_q <= '0;
      err_cnt_q <= '0;
      multi_q   <= 1'b0;
`ifdef TMR_SCRUB_LOG_EN
      err_addr     <= '0;
      err_syndrome <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (scrub_en) ivl_cnt <= CNT_LOAD;
        S_WAIT: if (ivl_cnt != '0) ivl_cnt <= ivl_cnt - IW'(1);
        S_CHECK: begin
          wr_data_q <= voted;
          if (!collide) begin
            if (multi) multi_q <= 1'b1;
`ifdef TMR_SCRUB_LOG_EN
            if (mismatch) begin
              err_addr     <= addr;
              err_syndrome <= syn;
            end
`endif
          end
        end
        S_WRITE: if (wr_gnt && !collide && err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + CNT_W'(1);
        S_NEXT: begin
          addr    <= (addr == ADDR_LAST) ? '0 : addr + AW'(1);
          ivl_cnt <= CNT_LOAD;
        end
        default: ;
      endcase
    end
  end

  assign rd_en     = (state == S_READ);
  assign wr_req    = (state == S_WRITE);
  assign busy      = (state != S_IDLE) && (state != S_WAIT);
  assign rd_addr   = addr;
  assign wr_addr   = addr;
  assign wr_data   = wr_data_q;
  assign err_cnt   = err_cnt_q;
  assign multi_err = multi_q;

endmodule

// File: doc/tmr_scrub_ctrl.md
Name: tmr_scrub_ctrl

Overview:
- Scrub controller for a bank of triplicated (LTMR) register words, each read through a bitwise 2-of-3 majority voter.
- Periodically walks every word, compares the three copies against the voted value, and writes the voted value back to all three copies on mismatch.
- Shares the bank write port with the functional datapath through a request/grant handshake; the functional path always has priority.

Parameters:
- N_WORDS, 8, number of triplicated words in the bank (>=2)
- W, 8, word width in bits
- INTERVAL, 16, idle cycles between word visits (>=1)
- CNT_W, 8, width of the saturating corrected-error counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- scrub_en  in  1  enables scanning; sampled at each visit start
- rd_en  out  1  bank read strobe; copies are valid the following cycle
- rd_addr  out  clog2(N_WORDS)  address of the word being scrubbed
- rd_copy0, rd_copy1, rd_copy2  in  W each  the three stored copies
- wr_req  out  1  request for the shared bank write port
- wr_gnt  in  1  write port granted this cycle
- wr_addr  out  clog2(N_WORDS)  scrub write address (equals rd_addr)
- wr_data  out  W  voted value, written to all three copies
- func_wr  in  1  functional write in progress this cycle
- func_addr  in  clog2(N_WORDS)  functional write address
- err_cnt  out  CNT_W  corrected words, saturating
- multi_err  out  1  sticky: more than one copy disagreed with the vote
- busy  out  1  high in every state except IDLE/WAIT

Behaviour:
- Reset values: all outputs 0, internal address 0, interval counter 0, state IDLE.
- Voter: voted = (c0&c1)|(c1&c2)|(c0&c2), bitwise. mismatch = any copy != voted. multi = at least two copies != voted.
- FSM states and transitions:
  - IDLE: when scrub_en=1, go to WAIT and load the counter with INTERVAL-1.
  - WAIT: decrement the counter. At 0, go to READ if scrub_en=1, else IDLE.
  - READ: rd_en=1 for exactly 1 cycle, then CHECK.
  - CHECK: register the copies and voted value. On mismatch go to WRITE, else NEXT. If multi, set multi_err (sticky until reset).
  - WRITE: hold wr_req=1, wr_addr and wr_data stable until wr_gnt=1. On grant, err_cnt += 1 (saturate at 2^CNT_W-1), then NEXT.
  - NEXT: address += 1, wrapping N_WORDS-1 to 0. Load the counter and go to WAIT.
- Latency: a clean word takes INTERVAL+3 cycles per visit. A mismatching word takes INTERVAL+3 plus the cycles until grant (at least 1).
- Collision: func_wr=1 with func_addr==rd_addr in CHECK or WRITE aborts the visit. Drop wr_req the next cycle, do not count, go to NEXT. The functional write supersedes the stale voted data.
- func_wr to other addresses has no effect on the visit.
- wr_req never deasserts before wr_gnt except on a collision abort.
- scrub_en falling mid-visit: the current visit completes; the FSM then returns to IDLE from WAIT.
- Asynchronous reset mid-visit: wr_req and rd_en drop immediately. No partial state is retained; the scan restarts at address 0.

Optional Feature:
- TMR_SCRUB_LOG_EN defined:
  - Adds output err_addr [clog2(N_WORDS)] and output err_syndrome [3]. err_syndrome bit i = copy i differed from the vote.
  - Both update in CHECK on every mismatch (last-error log) and reset to 0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- All words clean, scrub_en=1, INTERVAL=16, N_WORDS=8 -> rd_addr visits 0..7 then 0, one visit every 19 cycles; wr_req never asserts; err_cnt=0.
- Word 3 copies {0xA5,0xA5,0xA4}, wr_gnt tied 1 -> at word 3: wr_req for 1 cycle, wr_data=0xA5, wr_addr=3; err_cnt=1; multi_err=0.
- Word 5 copies {0xF0,0x0F,0xFF} -> voted 0xFF; multi_err=1 and remains 1; err_cnt increments after the grant.
- Mismatch with wr_gnt held 0 for 4 cycles -> wr_req stays high 5 cycles with stable wr_data; exactly 1 count.
- Mismatch at word 2 with func_wr=1, func_addr=2 during WRITE -> wr_req drops, err_cnt unchanged, next visit is word 3.
- rst_n pulsed low while wr_req=1 -> all outputs 0 asynchronously; after release, first read is address 0.
